// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared sizes and word type for the modport_mem storage block
package mem_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word storage with synchronous clear, write port and registered read port
module mem_array #(
   parameter int Data_Width = 32,
   parameter int Addr_Width = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [Addr_Width-1:0] addr,
   input  logic [Data_Width-1:0] wr_data,
   output logic [Data_Width-1:0] rd_data
);
   localparam int Depth = 1 << Addr_Width;

   logic [Data_Width-1:0] mem [Depth];
   logic [Data_Width-1:0] rd_q;

   // Read and write share one block so a same-address read returns the pre-write word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
         rd_q <= '0;
      end else begin
         if (rd_en) begin
            rd_q <= mem[addr];
         end
         if (wr_en) begin
            mem[addr] <= wr_data;
         end
      end
   end

   assign rd_data = rd_q;
endmodule

// File: rtl/modport_mem.sv
// rtl/modport_mem.sv - single-port synchronous memory with registered read data and read-valid strobe
module modport_mem
   import mem_pkg::*;
#(
   parameter int Data_Width = DATA_WIDTH,
   parameter int Addr_Width = ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  Rst_n,
   input  logic                  Wr_En,
   input  logic                  Rd_En,
   input  logic [Addr_Width-1:0] Address,
   input  logic [Data_Width-1:0] Data_in,
   output logic [Data_Width-1:0] Data_out,
   output logic                  Valid_out
);
   logic valid_q;

   // The array's read register only loads on Rd_En, so Data_out holds between reads.
   mem_array #(
      .Data_Width (Data_Width),
      .Addr_Width (Addr_Width)
   ) u_mem_array (
      .clk     (CLK),
      .rst_n   (Rst_n),
      .wr_en   (Wr_En),
      .rd_en   (Rd_En),
      .addr    (Address),
      .wr_data (Data_in),
      .rd_data (Data_out)
   );

   always_ff @(posedge CLK) begin
      if (!Rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= Rd_En;
      end
   end

   assign Valid_out = valid_q;
endmodule

// File: tb/tb_modport_mem.sv
// tb/tb_modport_mem.sv - directed and randomized self-checking bench for modport_mem
module tb_modport_mem;
   import mem_pkg::*;

   logic                  CLK;
   logic                  Rst_n;
   logic                  Wr_En;
   logic                  Rd_En;
   logic [ADDR_WIDTH-1:0] Address;
   word_t                 Data_in;
   word_t                 Data_out;
   logic                  Valid_out;

   int errors = 0;
   int checks = 0;

   word_t model [DEPTH];
   word_t exp_data;
   logic  exp_valid;
   int    valid_run;

   modport_mem #(
      .Data_Width (DATA_WIDTH),
      .Addr_Width (ADDR_WIDTH)
   ) dut (
      .CLK       (CLK),
      .Rst_n     (Rst_n),
      .Wr_En     (Wr_En),
      .Rd_En     (Rd_En),
      .Address   (Address),
      .Data_in   (Data_in),
      .Data_out  (Data_out),
      .Valid_out (Valid_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one command, clock it, advance the reference model, then check both outputs.
   task automatic cyc(input logic rst_n, input logic wr, input logic rd,
                      input int addr, input word_t data);
      Rst_n   = rst_n;
      Wr_En   = wr;
      Rd_En   = rd;
      Address = addr[ADDR_WIDTH-1:0];
      Data_in = data;
      @(posedge CLK);
      if (!rst_n) begin
         foreach (model[i]) model[i] = '0;
         exp_data  = '0;
         exp_valid = 1'b0;
      end else begin
         if (rd) exp_data = model[addr % DEPTH];
         exp_valid = rd;
         if (wr) model[addr % DEPTH] = data;
      end
      #1;
      chk("data_out", Data_out, exp_data);
      chk("valid_out", {31'b0, Valid_out}, {31'b0, exp_valid});
   endtask

   initial begin
      foreach (model[i]) model[i] = '0;
      exp_data  = '0;
      exp_valid = 1'b0;

      // Reset held two cycles while a read is requested
      cyc(1'b0, 1'b0, 1'b1, 3, '0);
      cyc(1'b0, 1'b0, 1'b1, 3, '0);
      chk("reset_data", Data_out, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 3, '0);
      chk("post_reset_read", Data_out, 32'h0);
      chk("post_reset_valid", {31'b0, Valid_out}, 32'h1);

      // Write then read
      cyc(1'b1, 1'b1, 1'b0, 5, 32'hDEADBEEF);
      cyc(1'b1, 1'b0, 1'b1, 5, '0);
      chk("wr_rd_data", Data_out, 32'hDEADBEEF);
      cyc(1'b1, 1'b0, 1'b0, 0, '0);
      chk("idle_valid", {31'b0, Valid_out}, 32'h0);

      // Full sweep, then back-to-back reads
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0, i, 32'hA5A50000 + i);
      valid_run = 0;
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 1'b0, 1'b1, i, '0);
         chk("sweep_data", Data_out, 32'hA5A50000 + i);
         if (Valid_out) valid_run++;
      end
      chk("sweep_valid_run", valid_run, DEPTH);

      // Simultaneous write and read returns the old word
      cyc(1'b1, 1'b1, 1'b0, 7, 32'h11111111);
      cyc(1'b1, 1'b1, 1'b1, 7, 32'h22222222);
      chk("rbw_old", Data_out, 32'h11111111);
      cyc(1'b1, 1'b0, 1'b1, 7, '0);
      chk("rbw_new", Data_out, 32'h22222222);

      // Hold while idle, with junk on address/data
      cyc(1'b1, 1'b1, 1'b0, 9, 32'h12345678);
      cyc(1'b1, 1'b0, 1'b1, 9, '0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0, $urandom_range(0, DEPTH-1), $urandom);
         chk("hold_data", Data_out, 32'h12345678);
      end

      // Mid-run reset clears contents
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, i, $urandom | 32'h1);
      cyc(1'b0, 1'b1, 1'b1, 0, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1, i, '0);
         chk("mid_reset_clear", Data_out, 32'h0);
      end

      // Randomized traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH-1), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
